// File: rtl/byte_packer.sv
// Packs a stream of bytes little-endian into BYTES-wide words behind a registered
// ready/valid output; a flush forces a partially filled word out.
module byte_packer #(
  parameter int BYTES = 4,
  parameter int CW    = $clog2(BYTES + 1)
) (
  input  logic                 clock_port,
  input  logic                 reset_port,
  input  logic                 clear,
  input  logic                 flush,
  input  logic [7:0]           input_port_data,
  input  logic                 input_port_valid,
  output logic                 input_port_ready,
  output logic [8*BYTES-1:0]   output_port_data,
  output logic [CW-1:0]        output_port_bytes,
  output logic                 output_port_valid,
  input  logic                 output_port_ready
);

  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [8*BYTES-1:0] acc_data, acc_data_nxt, acc_merged;
  logic [CW-1:0]      acc_count, acc_count_nxt, eff_count;
  logic [8*BYTES-1:0] out_data, out_data_nxt;
  logic [CW-1:0]      out_bytes, out_bytes_nxt;
  logic               out_valid, out_valid_nxt;
  logic               flush_pending, flush_pending_nxt;
  logic               in_acc, out_free, load;

  // Ready comes from registered state only, so no path from output_port_ready or flush.
  assign input_port_ready  = ~flush_pending & ~((acc_count == LAST) & out_valid);
  assign output_port_data  = out_data;
  assign output_port_bytes = out_bytes;
  assign output_port_valid = out_valid;

  always_comb begin
    in_acc    = input_port_valid & input_port_ready;
    out_free  = ~out_valid | output_port_ready;
    eff_count = acc_count + CW'(in_acc);
    acc_merged = acc_data;
    for (int k = 0; k < BYTES; k++) begin
      if (in_acc && (acc_count == CW'(k))) acc_merged[8*k +: 8] = input_port_data;
    end

    acc_data_nxt      = acc_data;
    acc_count_nxt     = acc_count;
    flush_pending_nxt = flush_pending;
    load              = 1'b0;

    // Input is blocked while a flush is pending, so acc_merged equals acc_data there.
    if (flush_pending) begin
      if (out_free) begin
        load              = 1'b1;
        flush_pending_nxt = 1'b0;
      end
    end else if (in_acc && (acc_count == LAST)) begin
      load = 1'b1;
    end else if (flush && (eff_count != '0)) begin
      if (out_free) begin
        load = 1'b1;
      end else begin
        acc_data_nxt      = acc_merged;
        acc_count_nxt     = eff_count;
        flush_pending_nxt = 1'b1;
      end
    end else if (in_acc) begin
      acc_data_nxt  = acc_merged;
      acc_count_nxt = eff_count;
    end

    out_data_nxt  = out_data;
    out_bytes_nxt = out_bytes;
    out_valid_nxt = out_valid;
    if (load) begin
      out_data_nxt  = acc_merged;
      out_bytes_nxt = eff_count;
      out_valid_nxt = 1'b1;
      acc_data_nxt  = '0;
      acc_count_nxt = '0;
    end else if (out_valid && output_port_ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) begin
      acc_data      <= '0;
      acc_count     <= '0;
      out_data      <= '0;
      out_bytes     <= '0;
      out_valid     <= 1'b0;
      flush_pending <= 1'b0;
    end else if (clear) begin
      acc_data      <= '0;
      acc_count     <= '0;
      out_data      <= '0;
      out_bytes     <= '0;
      out_valid     <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      acc_data      <= acc_data_nxt;
      acc_count     <= acc_count_nxt;
      out_data      <= out_data_nxt;
      out_bytes     <= out_bytes_nxt;
      out_valid     <= out_valid_nxt;
      flush_pending <= flush_pending_nxt;
    end
  end

endmodule

// File: tb/tb_byte_packer.sv
// Bench for byte_packer: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the packing rules.
module tb_byte_packer;
  localparam int BYTES = 4;
  localparam int CW    = $clog2(BYTES + 1);

  logic               clock_port = 1'b0;
  logic               reset_port, clear, flush;
  logic [7:0]         input_port_data;
  logic               input_port_valid, input_port_ready;
  logic [8*BYTES-1:0] output_port_data;
  logic [CW-1:0]      output_port_bytes;
  logic               output_port_valid, output_port_ready;

  byte_packer #(.BYTES(BYTES), .CW(CW)) dut (
    .clock_port(clock_port), .reset_port(reset_port), .clear(clear), .flush(flush),
    .input_port_data(input_port_data), .input_port_valid(input_port_valid),
    .input_port_ready(input_port_ready), .output_port_data(output_port_data),
    .output_port_bytes(output_port_bytes), .output_port_valid(output_port_valid),
    .output_port_ready(output_port_ready)
  );

  always #5 clock_port = ~clock_port;

  int checks = 0;
  int errors = 0;

  // Model: accepted-but-unemitted bytes in a queue, plus the presented word.
  byte unsigned       acc_q[$];
  bit                 m_ov, m_pend, m_zero;
  logic [8*BYTES-1:0] m_od;
  logic [CW-1:0]      m_ob;

  function automatic bit m_ready();
    return !m_pend && !((acc_q.size() == BYTES - 1) && m_ov);
  endfunction

  task automatic model_reset();
    acc_q.delete();
    m_ov = 0; m_pend = 0; m_zero = 1; m_od = '0; m_ob = '0;
  endtask

  task automatic emit();
    m_od = '0;
    foreach (acc_q[k]) m_od = m_od | ((8*BYTES)'(acc_q[k]) << (8*k));
    m_ob = CW'(acc_q.size());
    m_ov = 1; m_zero = 0;
    acc_q.delete();
  endtask

  task automatic model_step();
    bit in_acc, free, loaded;
    if (!reset_port || clear) begin
      model_reset();
      return;
    end
    in_acc = input_port_valid && m_ready();
    free   = !m_ov || output_port_ready;
    loaded = 0;
    if (m_pend) begin
      if (free) begin emit(); m_pend = 0; loaded = 1; end
    end else begin
      if (in_acc) acc_q.push_back(input_port_data);
      if (acc_q.size() == BYTES) begin
        emit(); loaded = 1;
      end else if (flush && acc_q.size() > 0) begin
        if (free) begin emit(); loaded = 1; end
        else m_pend = 1;
      end
    end
    if (!loaded && m_ov && output_port_ready) m_ov = 0;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all(string tag);
    chk({tag, ".valid"}, 64'(output_port_valid), 64'(m_ov));
    chk({tag, ".ready"}, 64'(input_port_ready), 64'(m_ready()));
    if (m_ov || m_zero) begin
      chk({tag, ".data"},  64'(output_port_data),  64'(m_od));
      chk({tag, ".bytes"}, 64'(output_port_bytes), 64'(m_ob));
    end
  endtask

  task automatic step(string tag, bit v, logic [7:0] d, bit fl, bit r, bit c = 0);
    input_port_valid  = v;
    input_port_data   = d;
    flush             = fl;
    output_port_ready = r;
    clear             = c;
    model_step();
    @(posedge clock_port);
    #1;
    cmp_all(tag);
  endtask

  // Pushes byte values first..first+n-1, retrying each until the model says accepted.
  task automatic push_seq(string tag, logic [7:0] first, int n, bit r);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 50) begin
      bit acc = m_ready();
      step(tag, 1, first + 8'(i), 0, r);
      if (acc) i++;
      guard++;
    end
    chk({tag, ".budget"}, 64'(i), 64'(n));
  endtask

  initial begin
    reset_port = 0; clear = 0; flush = 0; input_port_valid = 0;
    input_port_data = '0; output_port_ready = 1;
    model_reset();
    #1;
    chk("rst.async_valid", 64'(output_port_valid), 64'd0);
    step("rst", 0, 0, 0, 1);
    step("rst", 0, 0, 0, 1);
    reset_port = 1;
    chk("rst.ready", 64'(input_port_ready), 64'd1);

    // Streaming with ready high
    step("stream", 1, 8'h11, 0, 1);
    step("stream", 1, 8'h22, 0, 1);
    step("stream", 1, 8'h33, 0, 1);
    step("stream", 1, 8'h44, 0, 1);
    chk("stream.w1", 64'(output_port_data), 64'h44332211);
    chk("stream.w1b", 64'(output_port_bytes), 64'd4);
    step("stream", 1, 8'h55, 0, 1);
    step("stream", 1, 8'h66, 0, 1);
    step("stream", 1, 8'h77, 0, 1);
    step("stream", 1, 8'h88, 0, 1);
    chk("stream.w2", 64'(output_port_data), 64'h88776655);
    chk("stream.w2v", 64'(output_port_valid), 64'd1);
    step("stream", 0, 0, 0, 1);

    // Partial flush
    step("pflush", 1, 8'hA1, 0, 1);
    step("pflush", 1, 8'hB2, 1, 1);
    chk("pflush.data", 64'(output_port_data), 64'h0000B2A1);
    chk("pflush.bytes", 64'(output_port_bytes), 64'd2);
    step("pflush", 0, 0, 0, 1);
    push_seq("pflush.after", 8'h21, 4, 1);
    chk("pflush.clean", 64'(output_port_data), 64'h24232221);
    step("pflush", 0, 0, 0, 1);

    // Back-pressure
    for (int k = 0; k < 8; k++) step("bp", 1, 8'h01 + 8'(acc_q.size() + (m_ov ? 4 : 0)), 0, 0);
    chk("bp.ready_low", 64'(input_port_ready), 64'd0);
    chk("bp.held", 64'(output_port_data), 64'h04030201);
    step("bp.release", 1, 8'h08, 0, 1);
    step("bp.release", 1, 8'h08, 0, 1);
    chk("bp.w2", 64'(output_port_data), 64'h08070605);
    chk("bp.w2v", 64'(output_port_valid), 64'd1);
    step("bp", 0, 0, 0, 1);

    // Pending flush behind a held word
    push_seq("pend.fill", 8'hD1, 4, 0);
    step("pend", 1, 8'hC3, 0, 0);
    step("pend", 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) step("pend.blocked", 1, 8'h55, 0, 0);
    chk("pend.ready_low", 64'(input_port_ready), 64'd0);
    step("pend", 0, 0, 0, 1);
    chk("pend.data", 64'(output_port_data), 64'h000000C3);
    chk("pend.bytes", 64'(output_port_bytes), 64'd1);
    chk("pend.valid", 64'(output_port_valid), 64'd1);
    step("pend", 0, 0, 0, 1);

    // Flush with an empty accumulator
    for (int k = 0; k < 5; k++) begin
      step("eflush", 0, 0, 1, 1);
      chk("eflush.valid", 64'(output_port_valid), 64'd0);
    end

    // Synchronous clear mid-word
    push_seq("clr.fill", 8'h61, 3, 1);
    step("clr", 0, 0, 0, 1, 1);
    push_seq("clr.after", 8'h71, 4, 1);
    chk("clr.clean", 64'(output_port_data), 64'h74737271);
    step("clr", 0, 0, 0, 1);

    // Asynchronous reset mid-word with a held word
    push_seq("arst.hold", 8'h81, 4, 0);
    push_seq("arst.fill", 8'h91, 3, 0);
    #2 reset_port = 0;
    #1;
    chk("arst.valid", 64'(output_port_valid), 64'd0);
    chk("arst.data", 64'(output_port_data), 64'd0);
    chk("arst.ready", 64'(input_port_ready), 64'd1);
    model_reset();
    step("arst", 0, 0, 0, 1);
    reset_port = 1;
    push_seq("arst.after", 8'hE1, 4, 1);
    chk("arst.clean", 64'(output_port_data), 64'hE4E3E2E1);
    step("arst", 0, 0, 0, 1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
